// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
// The state encoding is fixed so waveforms and debug scripts stay stable.
package fetch_sequencer_pkg;

  localparam int FS_AW    = 32;
  localparam int FS_DW    = 32;
  localparam int FS_CNT_W = 16;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2,
    FS_KILL = 2'd3
  } fs_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding slot behind the fetch output register.
// Clear wins over load, and load wins over drain.
module fetch_skid_buf
  import fetch_sequencer_pkg::*;
#(
  parameter int AW = FS_AW,
  parameter int DW = FS_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_drain,
  input  logic          i_clear,
  input  logic [AW-1:0] i_pc,
  input  logic [DW-1:0] i_instr,
  output logic          o_valid,
  output logic [AW-1:0] o_pc,
  output logic [DW-1:0] o_instr
);

  logic          r_valid;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_instr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control: drives the PC enable, a req/ack instruction memory port and
// a two-deep {pc, instr} queue toward decode, squashing wrong-path fetches.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int AW    = FS_AW,
  parameter int DW    = FS_DW,
  parameter int CNT_W = FS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    pc,
  input  logic             redirect,
  output logic             pc_en,
  output logic             imem_req,
  output logic [AW-1:0]    imem_addr,
  input  logic             imem_ack,
  input  logic [DW-1:0]    imem_rdata,
  output logic             id_valid,
  output logic [DW-1:0]    id_instr,
  output logic [AW-1:0]    id_pc,
  input  logic             id_ready,
  output logic [CNT_W-1:0] starve_cnt
);

  fs_state_e        r_state;
  fs_state_e        w_state_next;
  logic [AW-1:0]    r_kill_addr;
  logic             r_id_valid;
  logic [DW-1:0]    r_id_instr;
  logic [AW-1:0]    r_id_pc;
  logic [CNT_W-1:0] r_starve_cnt;

  logic             w_xfer;
  logic             w_capture;
  logic             w_cap_to_out;
  logic             w_skid_load;
  logic             w_skid_drain;
  logic             w_skid_full_next;
  logic             w_skid_valid;
  logic [AW-1:0]    w_skid_pc;
  logic [DW-1:0]    w_skid_instr;
  logic             w_pc_en;
  logic             w_kill_load;

  assign w_xfer       = r_id_valid && id_ready;
  assign w_capture    = (r_state == FS_REQ) && imem_ack && !redirect;
  // New data lands in the output register only when that slot is free after
  // this edge; otherwise it goes to the skid entry.
  assign w_cap_to_out = w_capture && (!r_id_valid || (w_xfer && !w_skid_valid));
  assign w_skid_load  = w_capture && !w_cap_to_out;
  assign w_skid_drain = w_xfer && w_skid_valid;
  assign w_skid_full_next = w_skid_load || (w_skid_valid && !w_skid_drain);

  always_comb begin
    w_state_next = r_state;
    w_pc_en      = 1'b0;
    w_kill_load  = 1'b0;
    case (r_state)
      FS_IDLE: begin
        w_pc_en      = redirect;
        w_state_next = FS_REQ;
      end
      FS_REQ: begin
        if (imem_ack) begin
          w_pc_en = 1'b1;
          if (!redirect && w_skid_full_next) begin
            w_state_next = FS_HOLD;
          end
        end else if (redirect) begin
          w_pc_en      = 1'b1;
          w_kill_load  = 1'b1;
          w_state_next = FS_KILL;
        end
      end
      FS_HOLD: begin
        if (redirect) begin
          w_pc_en      = 1'b1;
          w_state_next = FS_REQ;
        end else if (w_skid_drain) begin
          w_state_next = FS_REQ;
        end
      end
      FS_KILL: begin
        // The in-flight word belongs to the old path and is thrown away.
        w_pc_en = redirect;
        if (imem_ack) begin
          w_state_next = FS_REQ;
        end
      end
      default: w_state_next = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FS_IDLE;
      r_kill_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_kill_load) begin
        r_kill_addr <= pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
    end else if (redirect) begin
      r_id_valid <= 1'b0;
    end else if (w_xfer && w_skid_valid) begin
      r_id_valid <= 1'b1;
      r_id_instr <= w_skid_instr;
      r_id_pc    <= w_skid_pc;
    end else if (w_cap_to_out) begin
      r_id_valid <= 1'b1;
      r_id_instr <= imem_rdata;
      r_id_pc    <= pc;
    end else if (w_xfer) begin
      r_id_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (id_ready && !r_id_valid && (r_starve_cnt != '1)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  fetch_skid_buf #(
    .AW(AW),
    .DW(DW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_clear (redirect),
    .i_pc    (pc),
    .i_instr (imem_rdata),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

  assign pc_en      = w_pc_en;
  assign imem_req   = (r_state == FS_REQ) || (r_state == FS_KILL);
  assign imem_addr  = (r_state == FS_KILL) ? r_kill_addr : pc;
  assign id_valid   = r_id_valid;
  assign id_instr   = r_id_instr;
  assign id_pc      = r_id_pc;
  assign starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run scored
// against a sequential-PC model of the fetched instruction stream.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        redirect = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        id_ready = 1'b0;
  logic [31:0] target = '0;

  logic        pc_en, imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc;
  logic [15:0] starve_cnt;
  logic        pc_en_b, imem_req_b, id_valid_b;
  logic [31:0] imem_addr_b, id_instr_b, id_pc_b;
  logic [3:0]  starve4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_sequencer #(.AW(32), .DW(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .pc(pc), .redirect(redirect), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_ready(id_ready), .starve_cnt(starve_cnt)
  );

  fetch_sequencer #(.AW(32), .DW(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .pc(pc), .redirect(redirect), .pc_en(pc_en_b),
    .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_valid(id_valid_b), .id_instr(id_instr_b),
    .id_pc(id_pc_b), .id_ready(id_ready), .starve_cnt(starve4)
  );

  // Advances one clock; the external PC register is modelled here.
  task automatic tick();
    logic en, rd;
    en = pc_en;
    rd = redirect;
    @(posedge clk);
    #1;
    if (en) pc = rd ? target : pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    rst = 1'b0;
    redirect = 1'b0;
    imem_ack = 1'b0;
    id_ready = 1'b0;
    pc = start_pc;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en: got %b expected 0", pc_en); end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", id_valid); end
    n_checks++; if (id_instr !== 32'd0 || id_pc !== 32'd0) begin n_fail++; $display("FAIL reset_id: got %h/%h expected 0/0", id_pc, id_instr); end
    n_checks++; if (starve_cnt !== 16'd0 || starve4 !== 4'd0) begin n_fail++; $display("FAIL reset_starve: got %0d/%0d expected 0/0", starve_cnt, starve4); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    do_reset(32'd0);
    imem_ack = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL stream_idle: got req=%b en=%b expected 0/0", imem_req, pc_en); end
    tick();
    id_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL stream_pc_en: cycle %0d got %b expected 1", i, pc_en); end
      n_checks++; if (imem_addr !== 32'(4 * (i - 1))) begin n_fail++; $display("FAIL stream_addr: got %h expected %h", imem_addr, 32'(4 * (i - 1))); end
      if (i >= 2) begin
        n_checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'(4 * (i - 2)) || id_instr !== mem_word(32'(4 * (i - 2)))) begin
          n_fail++; $display("FAIL stream_id: got v=%b pc=%h expected pc=%h", id_valid, id_pc, 32'(4 * (i - 2)));
        end
      end
      tick();
    end
    #1;
    n_checks++; if (starve_cnt !== 16'd1) begin n_fail++; $display("FAIL stream_starve: got %0d expected 1", starve_cnt); end
    $display("test_stream done");
  endtask

  task automatic test_backpressure();
    do_reset(32'd0);
    imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i >= 3) begin
        n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got req=%b en=%b expected 0/0", imem_req, pc_en); end
      end
      tick();
    end
    #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0) begin n_fail++; $display("FAIL bp_head: got v=%b pc=%h expected 1/0", id_valid, id_pc); end
    n_checks++; if (pc !== 32'd8 || imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_pc: got pc=%h req=%b expected 8/0", pc, imem_req); end
    id_ready = 1'b1;
    #1;
    tick();
    #1;
    n_checks++; if (id_pc !== 32'd4 || id_instr !== mem_word(32'd4)) begin n_fail++; $display("FAIL bp_second: got %h expected 4", id_pc); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin n_fail++; $display("FAIL bp_resume: got req=%b addr=%h expected 1/8", imem_req, imem_addr); end
    tick();
    #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'd8) begin n_fail++; $display("FAIL bp_third: got v=%b pc=%h expected 1/8", id_valid, id_pc); end
    $display("test_backpressure done");
  endtask

  task automatic test_inflight_kill();
    int pulses;
    pulses = 0;
    do_reset(32'h10);
    id_ready = 1'b1;
    #1;
    tick();
    redirect = 1'b1;
    target = 32'h40;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) imem_ack = 1'b1;
      #1;
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL kill_addr: cycle %0d got req=%b addr=%h expected 1/10", i, imem_req, imem_addr); end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL kill_leak: got id_valid=%b pc=%h expected 0", id_valid, id_pc); end
      pulses += int'(pc_en);
      tick();
      redirect = 1'b0;
      imem_ack = 1'b0;
    end
    #1;
    pulses += int'(pc_en);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL kill_next: got req=%b addr=%h expected 1/40", imem_req, imem_addr); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL kill_pulses: got %0d expected 1", pulses); end
    imem_ack = 1'b1;
    #1;
    tick();
    imem_ack = 1'b0;
    #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== mem_word(32'h40)) begin n_fail++; $display("FAIL kill_target: got v=%b pc=%h expected 1/40", id_valid, id_pc); end
    $display("test_inflight_kill done");
  endtask

  task automatic test_redirect_ack();
    do_reset(32'h1C);
    imem_ack = 1'b1;
    #1;
    tick();
    #1;
    tick();
    redirect = 1'b1;
    target = 32'h80;
    #1;
    n_checks++; if (imem_addr !== 32'h20 || pc_en !== 1'b1 || id_valid !== 1'b1) begin n_fail++; $display("FAIL ra_setup: got addr=%h en=%b v=%b expected 20/1/1", imem_addr, pc_en, id_valid); end
    tick();
    redirect = 1'b0;
    imem_ack = 1'b0;
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL ra_clear: got id_valid=%b expected 0", id_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_fail++; $display("FAIL ra_next: got req=%b addr=%h expected 1/80", imem_req, imem_addr); end
    $display("test_redirect_ack done");
  endtask

  task automatic test_async_reset();
    do_reset(32'h10);
    id_ready = 1'b1;
    #1;
    tick();
    redirect = 1'b1;
    target = 32'h40;
    #1;
    tick();
    redirect = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL ar_kill: got req=%b addr=%h expected 1/10", imem_req, imem_addr); end
    #2;
    rst = 1'b0;
    pc = 32'd0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL ar_outputs: got req=%b en=%b v=%b expected 0/0/0", imem_req, pc_en, id_valid); end
    n_checks++; if (starve_cnt !== 16'd0 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL ar_regs: got starve=%0d addr=%h expected 0/0", starve_cnt, imem_addr); end
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL ar_late_ack: got req=%b en=%b expected 0/0", imem_req, pc_en); end
    tick();
    imem_ack = 1'b0;
    #1;
    n_checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_fail++; $display("FAIL ar_restart: got v=%b req=%b addr=%h expected 0/1/0", id_valid, imem_req, imem_addr); end
    imem_ack = 1'b1;
    #1;
    tick();
    imem_ack = 1'b0;
    #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0) begin n_fail++; $display("FAIL ar_first: got v=%b pc=%h expected 1/0", id_valid, id_pc); end
    $display("test_async_reset done");
  endtask

  task automatic test_starve_sat();
    do_reset(32'd0);
    id_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i == 15) begin
        n_checks++; if (starve4 !== 4'd15) begin n_fail++; $display("FAIL sat_reach: got %0d expected 15", starve4); end
      end
      tick();
    end
    #1;
    n_checks++; if (starve4 !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", starve4); end
    n_checks++; if (starve_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_wide: got %0d expected 20", starve_cnt); end
    $display("test_starve_sat done");
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, kill_addr_m, p_id_pc, exp_addr;
    logic        kill_flag, exp_en;
    logic        p_req, p_ack, p_valid, p_ready, p_redirect;
    logic [15:0] starve_m;
    logic [3:0]  starve4_m;
    int          lat, xfers;
    exp_pc = 32'($urandom_range(0, 63)) << 2;
    do_reset(exp_pc);
    kill_flag = 1'b0; kill_addr_m = '0; starve_m = '0; starve4_m = '0;
    p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_redirect = 1'b0; p_id_pc = '0;
    lat = $urandom_range(0, 3);
    xfers = 0;
    for (int i = 0; i < 600; i++) begin
      redirect = ($urandom_range(0, 19) == 0);
      if (redirect) target = 32'($urandom_range(0, 255)) << 2;
      id_ready = ($urandom_range(0, 9) < 7);
      if (imem_req) begin
        if (lat == 0) begin imem_ack = 1'b1; lat = $urandom_range(0, 3); end
        else begin imem_ack = 1'b0; lat--; end
      end else begin
        imem_ack = ($urandom_range(0, 9) == 0);
      end
      #1;
      n_checks++; if (starve_cnt !== starve_m || starve4 !== starve4_m) begin n_fail++; $display("FAIL rnd_starve: got %0d/%0d expected %0d/%0d", starve_cnt, starve4, starve_m, starve4_m); end
      if (p_req && !p_ack) begin
        n_checks++; if (imem_req !== 1'b1 || imem_req_b !== 1'b1) begin n_fail++; $display("FAIL rnd_req_drop: got %b/%b expected 1", imem_req, imem_req_b); end
      end
      if (imem_req) begin
        exp_addr = kill_flag ? kill_addr_m : pc;
        n_checks++; if (imem_addr !== exp_addr || imem_addr_b !== exp_addr) begin n_fail++; $display("FAIL rnd_addr: got %h/%h expected %h", imem_addr, imem_addr_b, exp_addr); end
      end
      exp_en = redirect || (imem_req && imem_ack && !kill_flag);
      n_checks++; if (pc_en !== exp_en || pc_en_b !== exp_en) begin n_fail++; $display("FAIL rnd_pc_en: got %b/%b expected %b", pc_en, pc_en_b, exp_en); end
      if (p_valid && !p_ready && !p_redirect) begin
        n_checks++; if (id_valid !== 1'b1 || id_valid_b !== 1'b1 || id_pc !== p_id_pc) begin n_fail++; $display("FAIL rnd_hold: got v=%b pc=%h expected 1/%h", id_valid, id_pc, p_id_pc); end
      end
      if (id_valid && id_ready && !redirect) begin
        n_checks++;
        if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc) || id_valid_b !== 1'b1 || id_pc_b !== exp_pc || id_instr_b !== mem_word(exp_pc)) begin
          n_fail++; $display("FAIL rnd_xfer: got pc=%h instr=%h expected pc=%h instr=%h", id_pc, id_instr, exp_pc, mem_word(exp_pc));
        end
        $display("xfer pc=%h instr=%h", id_pc, id_instr);
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      if (kill_flag) begin
        if (imem_ack) kill_flag = 1'b0;
      end else if (redirect && imem_req && !imem_ack) begin
        kill_flag = 1'b1;
        kill_addr_m = pc;
      end
      if (id_ready && !id_valid) begin
        if (starve_m != 16'hFFFF) starve_m = starve_m + 16'd1;
        if (starve4_m != 4'hF) starve4_m = starve4_m + 4'd1;
      end
      if (redirect) exp_pc = target;
      p_req = imem_req; p_ack = imem_ack; p_valid = id_valid; p_ready = id_ready;
      p_redirect = redirect; p_id_pc = id_pc;
      tick();
    end
    redirect = 1'b0;
    n_checks++; if (xfers < 50) begin n_fail++; $display("FAIL rnd_progress: got %0d transfers expected at least 50", xfers); end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_inflight_kill();
    test_redirect_ack();
    test_async_reset();
    test_starve_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
